// File: rtl/rps_pkg.sv
// Shared encodings and round-outcome helper for the rock-paper-scissors match controller.
package rps_pkg;

  typedef enum logic [1:0] {
    MV_NONE     = 2'd0,
    MV_ROCK     = 2'd1,
    MV_PAPER    = 2'd2,
    MV_SCISSORS = 2'd3
  } move_e;

  typedef enum logic [1:0] {
    ST_WAIT_MOVE  = 2'd0,
    ST_ARMED      = 2'd1,
    ST_RESULT     = 2'd2,
    ST_MATCH_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RES_TIE  = 2'd0,
    RES_WIN  = 2'd1,
    RES_LOSE = 2'd2
  } result_e;

  localparam logic [7:0] LFSR_MASK = 8'hB8;

  // Player wins when (player - cpu) mod 3 == 1; the +3 bias keeps the difference non-negative.
  function automatic result_e rps_outcome(input move_e p, input move_e c);
    logic [2:0] diff;
    diff = 3'd3 + {1'b0, p} - {1'b0, c};
    case (diff)
      3'd1, 3'd4: return RES_WIN;
      3'd3:       return RES_TIE;
      default:    return RES_LOSE;
    endcase
  endfunction

endpackage

// File: rtl/rps_input_cond.sv
// Per-input conditioning: 2-FF synchroniser, optional debouncer, registered rising-edge pulse.
// Debouncer is built only when RPS_DEBOUNCE_EN is defined.
module rps_input_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clock,
  input  logic reset_button,
  input  logic btn_in,
  output logic pulse
);

  logic sync1_q, sync2_q;
  logic level;
  logic prev_q;
  logic pulse_q, pulse_d;

  always_ff @(posedge clock or negedge reset_button) begin
    if (!reset_button) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef RPS_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic          stable_q, stable_d;

  // Any return to the accepted level restarts the window, so short bounces never commit.
  always_comb begin
    db_cnt_d = db_cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      db_cnt_d = DB_LOAD;
    end else if (db_cnt_q == '0) begin
      stable_d = sync2_q;
      db_cnt_d = DB_LOAD;
    end else begin
      db_cnt_d = db_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_button) begin
    if (!reset_button) begin
      db_cnt_q <= DB_LOAD;
      stable_q <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      stable_q <= stable_d;
    end
  end

  assign level = stable_q;
`else
  assign level = sync2_q;
`endif

  always_comb begin
    pulse_d = level & ~prev_q;
  end

  always_ff @(posedge clock or negedge reset_button) begin
    if (!reset_button) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= level;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/rps_match_controller.sv
// Best-of-N rock-paper-scissors match against a counter or LFSR opponent.
// Input debouncing is enabled by defining RPS_DEBOUNCE_EN.
module rps_match_controller
  import rps_pkg::*;
#(
  parameter int unsigned ROUNDS_TO_WIN   = 3,
  parameter int unsigned CPU_MODE        = 0,
  parameter logic [7:0]  LFSR_SEED       = 8'hA5,
  parameter int unsigned RESULT_HOLD     = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  localparam int unsigned SW = $clog2(ROUNDS_TO_WIN + 1)
) (
  input  logic          clock,
  input  logic          reset_button,
  input  logic          rock_button,
  input  logic          paper_button,
  input  logic          scissors_button,
  input  logic          stop_signal,
  output logic          win_led,
  output logic          lose_led,
  output logic          tie_led,
  output logic          match_over,
  output logic [SW-1:0] player_score,
  output logic [SW-1:0] cpu_score,
  output logic [1:0]    player_move,
  output logic [1:0]    cpu_move
);

  localparam int unsigned   HW        = $clog2(RESULT_HOLD + 1);
  localparam logic [SW-1:0] WIN_SCORE = SW'(ROUNDS_TO_WIN);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(RESULT_HOLD - 1);

  logic [3:0] btn_raw, btn_pulse;
  assign btn_raw = {stop_signal, scissors_button, paper_button, rock_button};

  for (genvar i = 0; i < 4; i++) begin : g_in
    rps_input_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
      .clock        (clock),
      .reset_button (reset_button),
      .btn_in       (btn_raw[i]),
      .pulse        (btn_pulse[i])
    );
  end

  state_e          state_q, state_d;
  move_e           pmove_q, pmove_d, cmove_q, cmove_d;
  result_e         result_q, result_d, round_res;
  logic [HW-1:0]   hold_q, hold_d;
  logic [SW-1:0]   pscore_q, pscore_d, cscore_q, cscore_d;
  move_e           cnt_q, cnt_d, lfsr_move, cpu_now, new_move;
  logic [7:0]      lfsr_q, lfsr_d;
  logic            one_move, stop_p;

  // Both opponent sources always run; CPU_MODE only selects which one is sampled.
  always_comb begin
    cnt_d     = (cnt_q == MV_SCISSORS) ? MV_ROCK : move_e'(cnt_q + 2'd1);
    lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
    lfsr_move = move_e'(2'(lfsr_q % 8'd3) + 2'd1);
    cpu_now   = (CPU_MODE == 1) ? lfsr_move : cnt_q;
  end

  always_comb begin
    one_move = $onehot(btn_pulse[2:0]);
    stop_p   = btn_pulse[3];
    if (btn_pulse[0])      new_move = MV_ROCK;
    else if (btn_pulse[1]) new_move = MV_PAPER;
    else                   new_move = MV_SCISSORS;
  end

  always_comb begin
    state_d   = state_q;
    pmove_d   = pmove_q;
    cmove_d   = cmove_q;
    result_d  = result_q;
    hold_d    = hold_q;
    pscore_d  = pscore_q;
    cscore_d  = cscore_q;
    round_res = RES_TIE;
    case (state_q)
      ST_WAIT_MOVE: begin
        if (one_move) begin
          pmove_d = new_move;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (one_move) pmove_d = new_move;
        // A move arriving with the stop is applied before the reveal.
        if (stop_p) begin
          round_res = rps_outcome(pmove_d, cpu_now);
          cmove_d   = cpu_now;
          result_d  = round_res;
          hold_d    = HOLD_LOAD;
          state_d   = ST_RESULT;
          if (round_res == RES_WIN && pscore_q != WIN_SCORE) pscore_d = pscore_q + 1'b1;
          if (round_res == RES_LOSE && cscore_q != WIN_SCORE) cscore_d = cscore_q + 1'b1;
        end
      end
      ST_RESULT: begin
        if (hold_q == '0) begin
          if (pscore_q == WIN_SCORE || cscore_q == WIN_SCORE) begin
            state_d = ST_MATCH_DONE;
          end else begin
            state_d = ST_WAIT_MOVE;
            pmove_d = MV_NONE;
            cmove_d = MV_NONE;
          end
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_button) begin
    if (!reset_button) begin
      state_q  <= ST_WAIT_MOVE;
      pmove_q  <= MV_NONE;
      cmove_q  <= MV_NONE;
      result_q <= RES_TIE;
      hold_q   <= '0;
      pscore_q <= '0;
      cscore_q <= '0;
      cnt_q    <= MV_ROCK;
      lfsr_q   <= LFSR_SEED;
    end else begin
      state_q  <= state_d;
      pmove_q  <= pmove_d;
      cmove_q  <= cmove_d;
      result_q <= result_d;
      hold_q   <= hold_d;
      pscore_q <= pscore_d;
      cscore_q <= cscore_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
    end
  end

  always_comb begin
    win_led    = (state_q == ST_RESULT && result_q == RES_WIN) ||
                 (state_q == ST_MATCH_DONE && pscore_q == WIN_SCORE);
    lose_led   = (state_q == ST_RESULT && result_q == RES_LOSE) ||
                 (state_q == ST_MATCH_DONE && pscore_q != WIN_SCORE);
    tie_led    = (state_q == ST_RESULT && result_q == RES_TIE);
    match_over = (state_q == ST_MATCH_DONE);
  end

  assign player_score = pscore_q;
  assign cpu_score    = cscore_q;
  assign player_move  = pmove_q;
  assign cpu_move     = cmove_q;

endmodule

// File: tb/tb_rps_match_controller.sv
// Bench for rps_match_controller: counter-opponent and LFSR-opponent instances share stimulus.
module tb_rps_match_controller;
  import rps_pkg::*;

  localparam int         RTW  = 2;
  localparam int         HOLD = 4;
  localparam logic [7:0] SEED = 8'hA5;

  logic clock = 1'b0;
  logic reset_button = 1'b0;
  logic rock_button = 1'b0, paper_button = 1'b0, scissors_button = 1'b0, stop_signal = 1'b0;

  logic       win0, lose0, tie0, over0, win1, lose1, tie1, over1;
  logic [1:0] ps0, cs0, pm0, cm0, ps1, cs1, pm1, cm1;

  always #5 clock = ~clock;

  rps_match_controller #(.ROUNDS_TO_WIN(RTW), .CPU_MODE(0), .LFSR_SEED(SEED),
                         .RESULT_HOLD(HOLD), .DEBOUNCE_CYCLES(4)) dut0 (
    .clock(clock), .reset_button(reset_button), .rock_button(rock_button),
    .paper_button(paper_button), .scissors_button(scissors_button), .stop_signal(stop_signal),
    .win_led(win0), .lose_led(lose0), .tie_led(tie0), .match_over(over0),
    .player_score(ps0), .cpu_score(cs0), .player_move(pm0), .cpu_move(cm0));

  rps_match_controller #(.ROUNDS_TO_WIN(RTW), .CPU_MODE(1), .LFSR_SEED(SEED),
                         .RESULT_HOLD(HOLD), .DEBOUNCE_CYCLES(4)) dut1 (
    .clock(clock), .reset_button(reset_button), .rock_button(rock_button),
    .paper_button(paper_button), .scissors_button(scissors_button), .stop_signal(stop_signal),
    .win_led(win1), .lose_led(lose1), .tie_led(tie1), .match_over(over1),
    .player_score(ps1), .cpu_score(cs1), .player_move(pm1), .cpu_move(cm1));

  int checks = 0;
  int failures = 0;

  // Reference model: opponent sources as values "before the next edge", match as abstract phases.
  int         m_cnt;
  logic [7:0] m_lfsr;
  int         m_phase[2];   // 0 waiting, 1 armed, 2 showing result, 3 match over
  int         m_ps[2], m_cs[2], m_pm[2], m_cm[2], m_res[2];  // res: 0 tie, 1 win, 2 lose

  typedef struct {
    string      name;
    logic [2:0] mv;
    bit         stp;
    int         tgt;
    logic [11:0] exp_now;
    logic [11:0] exp_after;
  } vec_t;
  vec_t tbl[13];

  function automatic logic [11:0] pk(bit w, bit l, bit t, bit o, int ps, int cs, int pm, int cm);
    return {w, l, t, o, 2'(ps), 2'(cs), 2'(pm), 2'(cm)};
  endfunction

  function automatic logic [11:0] act(int d);
    if (d == 0) return {win0, lose0, tie0, over0, ps0, cs0, pm0, cm0};
    return {win1, lose1, tie1, over1, ps1, cs1, pm1, cm1};
  endfunction

  function automatic int judge(int p, int c);
    if (p == c) return 0;
    if ((p == 1 && c == 3) || (p == 2 && c == 1) || (p == 3 && c == 2)) return 1;
    return 2;
  endfunction

  function automatic logic [11:0] expect_of(int d);
    bit w, l, t, o;
    w = (m_phase[d] == 2 && m_res[d] == 1) || (m_phase[d] == 3 && m_ps[d] == RTW);
    l = (m_phase[d] == 2 && m_res[d] == 2) || (m_phase[d] == 3 && m_ps[d] != RTW);
    t = (m_phase[d] == 2 && m_res[d] == 0);
    o = (m_phase[d] == 3);
    return pk(w, l, t, o, m_ps[d], m_cs[d], m_pm[d], m_cm[d]);
  endfunction

  task automatic check(string name, logic [11:0] actual, logic [11:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_models(string tag);
    check({tag, "_cnt"}, act(0), expect_of(0));
    check({tag, "_lfsr"}, act(1), expect_of(1));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    m_cnt  = (m_cnt + 1) % 3;
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
  endtask

  task automatic clear_models();
    m_cnt  = 0;
    m_lfsr = SEED;
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0; m_ps[d] = 0; m_cs[d] = 0; m_pm[d] = 0; m_cm[d] = 0; m_res[d] = 0;
    end
  endtask

  task automatic do_reset();
    reset_button = 1'b0;
    rock_button = 1'b0; paper_button = 1'b0; scissors_button = 1'b0; stop_signal = 1'b0;
    #1;
    check("reset_async_cnt", act(0), 12'h000);
    check("reset_async_lfsr", act(1), 12'h000);
    tick();
    tick();
    @(negedge clock);
    reset_button = 1'b1;
    clear_models();
    tick();
  endtask

  task automatic model_step(int d, logic [2:0] mv, bit stp, int c);
    bit one;
    int nm;
    one = (mv == 3'b001) || (mv == 3'b010) || (mv == 3'b100);
    nm  = mv[0] ? 1 : (mv[1] ? 2 : 3);
    if (m_phase[d] == 0) begin
      if (one) begin m_pm[d] = nm; m_phase[d] = 1; end
    end else if (m_phase[d] == 1) begin
      if (one) m_pm[d] = nm;
      if (stp) begin
        m_cm[d]  = c;
        m_res[d] = judge(m_pm[d], c);
        if (m_res[d] == 1 && m_ps[d] < RTW) m_ps[d]++;
        if (m_res[d] == 2 && m_cs[d] < RTW) m_cs[d]++;
        m_phase[d] = 2;
      end
    end
  endtask

  task automatic model_resolve(int d);
    if (m_phase[d] == 2) begin
      if (m_ps[d] == RTW || m_cs[d] == RTW) begin
        m_phase[d] = 3;
      end else begin
        m_phase[d] = 0; m_pm[d] = 0; m_cm[d] = 0;
      end
    end
  endtask

  // Buttons are held for one cycle; the FSM reacts on the third edge after first sampling.
  task automatic press(logic [2:0] mv, bit stp, output int c0, output int c1);
    rock_button = mv[0]; paper_button = mv[1]; scissors_button = mv[2]; stop_signal = stp;
    tick();
    rock_button = 1'b0; paper_button = 1'b0; scissors_button = 1'b0; stop_signal = 1'b0;
    tick();
    tick();
    c0 = m_cnt + 1;
    c1 = int'(m_lfsr % 8'd3) + 1;
    tick();
  endtask

  task automatic do_action(logic [2:0] mv, bit stp, output logic [11:0] snap0);
    int c0, c1;
    press(mv, stp, c0, c1);
    model_step(0, mv, stp, c0);
    model_step(1, mv, stp, c1);
    snap0 = act(0);
    check_models("act");
    if (m_phase[0] == 2 || m_phase[1] == 2) begin
      for (int i = 1; i < HOLD; i++) begin
        tick();
        check_models("hold");
      end
      tick();
      model_resolve(0);
      model_resolve(1);
      check_models("after_hold");
    end
  endtask

  task automatic wait_counter(int tgt);
    for (int i = 0; i < 3 && m_cnt != tgt - 1; i++) tick();
  endtask

  initial begin
    logic [11:0] snap;
    int c0, c1, r, n;
    logic [2:0] mv;

    tbl[0]  = '{"rock",           3'b001, 1'b0, 0, pk(0,0,0,0,0,0,1,0), pk(0,0,0,0,0,0,1,0)};
    tbl[1]  = '{"win_stop",       3'b000, 1'b1, 3, pk(1,0,0,0,1,0,1,3), pk(0,0,0,0,1,0,0,0)};
    tbl[2]  = '{"paper",          3'b010, 1'b0, 0, pk(0,0,0,0,1,0,2,0), pk(0,0,0,0,1,0,2,0)};
    tbl[3]  = '{"tie_stop",       3'b000, 1'b1, 2, pk(0,0,1,0,1,0,2,2), pk(0,0,0,0,1,0,0,0)};
    tbl[4]  = '{"dual_move",      3'b011, 1'b0, 0, pk(0,0,0,0,1,0,0,0), pk(0,0,0,0,1,0,0,0)};
    tbl[5]  = '{"lone_stop",      3'b000, 1'b1, 0, pk(0,0,0,0,1,0,0,0), pk(0,0,0,0,1,0,0,0)};
    tbl[6]  = '{"rock_arm",       3'b001, 1'b0, 0, pk(0,0,0,0,1,0,1,0), pk(0,0,0,0,1,0,1,0)};
    tbl[7]  = '{"scissors_over",  3'b100, 1'b0, 0, pk(0,0,0,0,1,0,3,0), pk(0,0,0,0,1,0,3,0)};
    tbl[8]  = '{"lose_stop",      3'b000, 1'b1, 1, pk(0,1,0,0,1,1,3,1), pk(0,0,0,0,1,1,0,0)};
    tbl[9]  = '{"rock_arm2",      3'b001, 1'b0, 0, pk(0,0,0,0,1,1,1,0), pk(0,0,0,0,1,1,1,0)};
    tbl[10] = '{"paper_and_stop", 3'b010, 1'b1, 1, pk(1,0,0,0,2,1,2,1), pk(1,0,0,1,2,1,2,1)};
    tbl[11] = '{"done_move",      3'b100, 1'b0, 0, pk(1,0,0,1,2,1,2,1), pk(1,0,0,1,2,1,2,1)};
    tbl[12] = '{"done_stop",      3'b000, 1'b1, 0, pk(1,0,0,1,2,1,2,1), pk(1,0,0,1,2,1,2,1)};

    do_reset();
    for (int i = 0; i < 10; i++) tick();
    check("idle_cnt", act(0), 12'h000);
    check("idle_lfsr", act(1), 12'h000);
    check("idle_state", 12'(dut0.state_q), 12'(ST_WAIT_MOVE));

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].tgt != 0) wait_counter(tbl[i].tgt);
      do_action(tbl[i].mv, tbl[i].stp, snap);
      check({tbl[i].name, "_now"}, snap, tbl[i].exp_now);
      check({tbl[i].name, "_after"}, act(0), tbl[i].exp_after);
    end

    // Reset landing in the middle of a result display, and first LFSR reveal after reset.
    do_reset();
    do_action(3'b010, 1'b0, snap);
    press(3'b000, 1'b1, c0, c1);
    check("lfsr_first_reveal", {10'b0, cm1}, 12'(c1));
    check("cnt_result_led", {11'b0, win0 | lose0 | tie0}, 12'h001);
    tick();
    do_reset();

    for (int it = 0; it < 80; it++) begin
      if (m_phase[0] == 3 && m_phase[1] == 3) do_reset();
      r = $urandom_range(0, 9);
      n = $urandom_range(0, 2);
      mv = 3'(1 << n);
      case (r)
        0, 1, 2, 3: do_action(mv, 1'b0, snap);
        4: begin
          case (n)
            0: mv = 3'b011;
            1: mv = 3'b110;
            default: mv = 3'b111;
          endcase
          do_action(mv, 1'b0, snap);
        end
        5, 6, 7: do_action(3'b000, 1'b1, snap);
        8: do_action(mv, 1'b1, snap);
        default: begin
          for (int k = 0; k < $urandom_range(1, 5); k++) tick();
          check_models("idle");
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
